// File: rtl/telem_readout.sv
// telem_readout: frames the delay-line readout bit stream into syllables,
// tags each recovered word with an odd-parity error flag and queues it in a
// small FIFO that a downstream telemetry multiplexer drains by valid/ready.
module telem_readout #(
  parameter int SYL_BITS   = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                SIM_CLK,
  input  logic                SIM_RST,
  input  logic                DDLO,
  input  logic                BIT_STB,
  input  logic                SYL_SYNC,
  input  logic                ENA,
  input  logic                CLR,
  output logic [SYL_BITS-2:0] WORD_DATA,
  output logic                WORD_PERR,
  output logic                WORD_VALID,
  input  logic                WORD_READY,
  output logic                OVF,
  output logic [3:0]          SYNC_ERR_CNT,
  output logic                BUSY
);

  localparam int CW = $clog2(SYL_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(SYL_BITS - 1);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {HUNT, SHIFT, PUSH} state_t;

  state_t              state;
  logic [SYL_BITS-1:0] shreg;
  logic [CW-1:0]       bit_cnt;

  logic [SYL_BITS-2:0] mem_data [FIFO_DEPTH];
  logic                mem_perr [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;

  logic                start;
  logic                sync_err;
  logic [SYL_BITS-1:0] start_word;
  logic                full;
  logic                pop;
  logic                push_req;
  logic                push_ok;
  logic                drop;

  // A sync-marked strobe always begins a syllable; inside SHIFT it also
  // means the previous syllable was cut short.
  assign start      = BIT_STB & SYL_SYNC & ENA;
  assign sync_err   = (state == SHIFT) & start;
  assign start_word = {{(SYL_BITS-1){1'b0}}, DDLO};

  assign full     = (count == DEPTH);
  assign pop      = WORD_VALID & WORD_READY;
  assign push_req = (state == PUSH);
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign WORD_VALID = (count != '0);
  assign WORD_DATA  = WORD_VALID ? mem_data[rd_ptr] : '0;
  assign WORD_PERR  = WORD_VALID ? mem_perr[rd_ptr] : 1'b0;
  assign BUSY       = (state == SHIFT);

  // Framing state machine: hunt for sync, shift bits LSB-first, then a
  // single PUSH cycle that hands the finished syllable to the FIFO.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state   <= HUNT;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        HUNT, PUSH: begin
          if (start) begin
            shreg   <= start_word;
            bit_cnt <= CW'(1);
            state   <= SHIFT;
          end else begin
            state <= HUNT;
          end
        end
        SHIFT: begin
          if (!ENA) begin
            state <= HUNT;
          end else if (BIT_STB) begin
            if (SYL_SYNC) begin
              shreg   <= start_word;
              bit_cnt <= CW'(1);
            end else begin
              shreg[bit_cnt] <= DDLO;
              bit_cnt        <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) state <= PUSH;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  // FIFO storage; the parity tag is set when the full syllable has even weight.
  always_ff @(posedge SIM_CLK) begin
    if (push_ok) begin
      mem_data[wr_ptr] <= shreg[SYL_BITS-2:0];
      mem_perr[wr_ptr] <= ~(^shreg);
    end
  end

  // FIFO pointers and occupancy; a pop frees the slot for a same-cycle push.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow and saturating sync-error count; a new event beats CLR.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      OVF          <= 1'b0;
      SYNC_ERR_CNT <= '0;
    end else begin
      if (drop)     OVF <= 1'b1;
      else if (CLR) OVF <= 1'b0;

      if (sync_err) begin
        if (CLR)                        SYNC_ERR_CNT <= 4'd1;
        else if (SYNC_ERR_CNT != 4'hF)  SYNC_ERR_CNT <= SYNC_ERR_CNT + 1'b1;
      end else if (CLR) begin
        SYNC_ERR_CNT <= '0;
      end
    end
  end

endmodule

// File: tb/tb_telem_readout.sv
// tb_telem_readout: directed vectors and sequences for telem_readout, plus a
// randomized run scored against a queue-based model of syllable framing.
module tb_telem_readout;

  localparam int SYL_BITS   = 13;
  localparam int FIFO_DEPTH = 4;

  typedef logic [SYL_BITS-1:0] ent_t;

  typedef struct {
    logic [11:0] data;
    logic        par;
    logic [11:0] exp_data;
    logic        exp_perr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ddlo = 1'b0;
  logic        bit_stb = 1'b0;
  logic        syl_sync = 1'b0;
  logic        ena = 1'b1;
  logic        clr = 1'b0;
  logic        word_ready = 1'b0;
  logic [11:0] word_data;
  logic        word_perr;
  logic        word_valid;
  logic        ovf;
  logic [3:0]  sync_err_cnt;
  logic        busy;

  int n_cmp = 0;
  int n_fail = 0;

  // model state
  ent_t mq[$];
  bit   bits_q[$];
  bit   in_syl = 0;
  bit   push_pend = 0;
  ent_t pend_word = '0;
  bit   m_ovf = 0;
  int   m_err = 0;
  bit   scb_on = 0;

  telem_readout #(.SYL_BITS(SYL_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .SIM_CLK(clk), .SIM_RST(rst_n), .DDLO(ddlo), .BIT_STB(bit_stb),
    .SYL_SYNC(syl_sync), .ENA(ena), .CLR(clr), .WORD_DATA(word_data),
    .WORD_PERR(word_perr), .WORD_VALID(word_valid), .WORD_READY(word_ready),
    .OVF(ovf), .SYNC_ERR_CNT(sync_err_cnt), .BUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: bits collected per syllable, words kept in a queue.
  always @(posedge clk or negedge rst_n) begin
    bit popping, ovf_evt, err_evt;
    int ones;
    logic [11:0] d;
    if (!rst_n) begin
      mq.delete(); bits_q.delete();
      in_syl = 0; push_pend = 0; m_ovf = 0; m_err = 0;
    end else begin
      ovf_evt = 0; err_evt = 0;
      popping = (mq.size() > 0) && word_ready;
      if (popping) void'(mq.pop_front());
      if (push_pend) begin
        if (mq.size() < FIFO_DEPTH) mq.push_back(pend_word);
        else ovf_evt = 1;
      end
      push_pend = 0;
      if (!ena) begin
        in_syl = 0; bits_q.delete();
      end else if (bit_stb) begin
        if (syl_sync) begin
          if (in_syl) err_evt = 1;
          bits_q.delete(); bits_q.push_back(ddlo); in_syl = 1;
        end else if (in_syl) begin
          bits_q.push_back(ddlo);
        end
        if (in_syl && bits_q.size() == SYL_BITS) begin
          ones = 0; d = '0;
          for (int i = 0; i < SYL_BITS; i++) ones += int'(bits_q[i]);
          for (int i = 0; i < SYL_BITS - 1; i++) d[i] = bits_q[i];
          pend_word = {(ones % 2 == 0), d};
          push_pend = 1; in_syl = 0; bits_q.delete();
        end
      end
      if (ovf_evt) m_ovf = 1; else if (clr) m_ovf = 0;
      if (err_evt) m_err = clr ? 1 : ((m_err < 15) ? m_err + 1 : 15);
      else if (clr) m_err = 0;
    end
  end

  task automatic check_output();
    check("sb_valid", 32'(word_valid), 32'(mq.size() > 0));
    check("sb_busy", 32'(busy), 32'(in_syl));
    check("sb_ovf", 32'(ovf), 32'(m_ovf));
    check("sb_err", 32'(sync_err_cnt), 32'(m_err));
    if (mq.size() > 0) begin
      check("sb_data", 32'(word_data), 32'(mq[0][11:0]));
      check("sb_perr", 32'(word_perr), 32'(mq[0][12]));
    end
  endtask

  // Continuous scoreboard comparison mid-cycle.
  always @(negedge clk) if (scb_on && rst_n) check_output();

  task automatic send_bit(input logic d, input logic s, input int gap);
    @(negedge clk);
    ddlo = d; syl_sync = s; bit_stb = 1'b1;
    @(negedge clk);
    bit_stb = 1'b0; syl_sync = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic send_bits(input logic [11:0] data, input int n, input int first);
    for (int i = first; i < n; i++) send_bit(data[i], 1'(i == 0), 4);
  endtask

  task automatic strobe_last(input logic par);
    @(negedge clk);
    ddlo = par; bit_stb = 1'b1;
    @(negedge clk);
    bit_stb = 1'b0;
  endtask

  task automatic send_syl(input logic [11:0] data, input logic par);
    send_bits(data, SYL_BITS - 1, 0);
    strobe_last(par);
    repeat (3) @(negedge clk);
  endtask

  function automatic logic odd_par(input logic [11:0] d);
    return ~(^d);
  endfunction

  task automatic apply_stimulus(input vec_t v);
    word_ready = 1'b1;
    send_bits(v.data, SYL_BITS - 1, 0);
    strobe_last(v.par);
    check("lat_valid_push", 32'(word_valid), 0);
    check("lat_busy_push", 32'(busy), 0);
    @(negedge clk);
    check("lat_valid", 32'(word_valid), 1);
    check("vec_data", 32'(word_data), 32'(v.exp_data));
    check("vec_perr", 32'(word_perr), 32'(v.exp_perr));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vec_t vecs[7];
    vecs[0] = '{12'hA5C, 1'b1, 12'hA5C, 1'b0};
    vecs[1] = '{12'hA5C, 1'b0, 12'hA5C, 1'b1};
    vecs[2] = '{12'h000, 1'b1, 12'h000, 1'b0};
    vecs[3] = '{12'hFFF, 1'b1, 12'hFFF, 1'b0};
    vecs[4] = '{12'hFFF, 1'b0, 12'hFFF, 1'b1};
    vecs[5] = '{12'h3C3, 1'b0, 12'h3C3, 1'b1};
    vecs[6] = '{12'h001, 1'b0, 12'h001, 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(word_valid), 0);
    check("rst_data", 32'(word_data), 0);
    check("rst_perr", 32'(word_perr), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_err", 32'(sync_err_cnt), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    scb_on = 1;

    // nominal and parity vectors
    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i]);
    check("par_ovf", 32'(ovf), 0);
    check("par_err", 32'(sync_err_cnt), 0);

    // backpressure and overflow
    word_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send_syl(12'(k), odd_par(12'(k)));
      if (k == 4) check("ovf_before", 32'(ovf), 0);
    end
    check("ovf_after", 32'(ovf), 1);
    for (int k = 1; k <= 4; k++) begin
      check("drain_head", 32'(word_data), 32'(k));
      word_ready = 1'b1;
      @(negedge clk);
    end
    check("drain_empty", 32'(word_valid), 0);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    check("clr_ovf", 32'(ovf), 0);

    // full-and-pop in the PUSH cycle
    word_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_syl(12'h011 + 12'(k), odd_par(12'h011 + 12'(k)));
    send_bits(12'h015, SYL_BITS - 1, 0);
    strobe_last(odd_par(12'h015));
    word_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check("fp_head", 32'(word_data), 32'h010 + 32'(k));
    end
    @(negedge clk);
    check("fp_empty", 32'(word_valid), 0);
    check("fp_ovf", 32'(ovf), 0);

    // early sync
    word_ready = 1'b0;
    send_bits(12'h2AA, 6, 0);
    send_syl(12'h3C3, 1'b1);
    check("es_err", 32'(sync_err_cnt), 1);
    check("es_valid", 32'(word_valid), 1);
    check("es_data", 32'(word_data), 32'h3C3);
    check("es_perr", 32'(word_perr), 0);
    word_ready = 1'b1;
    @(negedge clk);
    check("es_single", 32'(word_valid), 0);
    send_bit(1'b1, 1'b1, 4);
    repeat (16) begin
      send_bit(1'b0, 1'b0, 4);
      send_bit(1'b0, 1'b1, 4);
    end
    check("es_sat", 32'(sync_err_cnt), 15);
    @(negedge clk);
    clr = 1'b1; bit_stb = 1'b1; syl_sync = 1'b1; ddlo = 1'b0;
    @(negedge clk);
    clr = 1'b0; bit_stb = 1'b0; syl_sync = 1'b0;
    check("es_clr_win", 32'(sync_err_cnt), 1);
    ena = 1'b0; @(negedge clk); ena = 1'b1;
    check("es_abort_busy", 32'(busy), 0);

    // ENA drop at bit 8
    send_bits(12'h5A5, 8, 0);
    @(negedge clk);
    ena = 1'b0; bit_stb = 1'b1; ddlo = 1'b1;
    @(negedge clk);
    bit_stb = 1'b0; ena = 1'b1;
    check("ena_busy", 32'(busy), 0);
    check("ena_err", 32'(sync_err_cnt), 1);
    send_bits(12'h5A5, SYL_BITS - 1, 9);
    strobe_last(1'b0);
    repeat (3) @(negedge clk);
    check("ena_noword", 32'(word_valid), 0);

    // asynchronous reset mid-syllable with words queued
    word_ready = 1'b0;
    send_syl(12'h111, odd_par(12'h111));
    send_syl(12'h222, odd_par(12'h222));
    check("rs_queued", 32'(word_valid), 1);
    send_bits(12'h333, 5, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rs_valid", 32'(word_valid), 0);
    check("rs_data", 32'(word_data), 0);
    check("rs_perr", 32'(word_perr), 0);
    check("rs_err", 32'(sync_err_cnt), 0);
    check("rs_busy", 32'(busy), 0);
    check("rs_ovf", 32'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized stream against the model
    for (int n = 0; n < 1500; n++) begin
      word_ready = 1'($urandom_range(3, 0) != 0);
      clr = 1'($urandom_range(49, 0) == 0);
      ena = 1'($urandom_range(59, 0) != 0);
      send_bit(1'($urandom_range(1, 0)), 1'($urandom_range(12, 0) == 0),
               int'($urandom_range(5, 2)));
    end
    clr = 1'b0; ena = 1'b1; word_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("end_empty", 32'(word_valid), 0);

    scb_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
